playlist_mcu: RTL and testbench
===============================

# playlist_mcu

Parametrised playback controller for the music player: turns single-cycle button pulses and the note player's `song_done` into the `play` enable, the selected `song` index, and a one-cycle `reset_player` strobe. Successor to the fixed 4-song play/pause/next controller. Adds a configurable song count, a previous button, and four end-of-song modes: stop, advance, loop-all and repeat-one. Sits between the button one-pulsers and the song reader / note player.

## Interface
- `NUM_SONGS`, 4: number of songs in ROM, ≥2, need not be a power of two.
- `SONG_W`, 2: width of `song`; must satisfy 2^SONG_W ≥ NUM_SONGS.
- `clk` input 1: system clock; all logic on the rising edge.
- `reset` input 1: synchronous, active-high reset.
- `play_button` input 1: one-cycle pulse; toggles play/pause.
- `next_button` input 1: one-cycle pulse; selects the next song.
- `prev_button` input 1: one-cycle pulse; selects the previous song.
- `mode_button` input 1: one-cycle pulse; cycles the end-of-song mode.
- `song_done` input 1: one-cycle pulse from the player at the end of the current song.
- `play` output 1: registered; high means the player advances.
- `reset_player` output 1: registered one-cycle strobe; the player restarts the current `song` from note 0.
- `song` output SONG_W: registered index of the selected song, range 0..NUM_SONGS-1.
- `mode` output 2: registered mode. 0=STOP, 1=ADVANCE, 2=LOOP_ALL, 3=REPEAT_ONE.

## Operation
- Play state machine has two states: PAUSED and PLAYING. Reset enters PAUSED.
- Reset values, applied at any edge with `reset`=1 regardless of other inputs:
  - `play`=0, `song`=0, `mode`=0.
  - `reset_player`=1, so the player is cleared during reset.
- Per-edge priority, highest first: reset > `song_done` > `next`/`prev` > `play_button`. `mode_button` is independent and applies in the same cycle as any of these.
- Behaviour at a `song_done` edge:
  - Ignored when PAUSED.
  - When PLAYING, the action depends on `mode`:
    - STOP: stay on `song`, go to PAUSED, pulse `reset_player`.
    - ADVANCE: if `song` < NUM_SONGS-1, set `song`+1, stay PLAYING, pulse `reset_player`. Otherwise set `song`=0, go to PAUSED, pulse `reset_player`.
    - LOOP_ALL: set `song`=(`song`+1) mod NUM_SONGS, stay PLAYING, pulse `reset_player`.
    - REPEAT_ONE: keep the same `song`, stay PLAYING, pulse `reset_player`.
- Next/prev buttons:
  - `next_button` only: `song`=(`song`+1) mod NUM_SONGS.
  - `prev_button` only: `song`=`song`-1, with 0 wrapping to NUM_SONGS-1.
  - Either one pulses `reset_player`. The PAUSED/PLAYING state is preserved; this differs from the previous controller, which did not preserve it.
  - Both high in the same cycle: no song change and no strobe. Priority continues downward, so `play_button` may still act.
- `play_button`: toggles PAUSED↔PLAYING. No strobe, so a pause/resume resumes mid-song.
  - Ignored when `song_done` or a single `next`/`prev` acts in the same cycle.
- `mode_button`: `mode`=(`mode`+1) mod 4. It takes effect for any `song_done` on later edges, not the same edge.
- Wrap arithmetic uses an explicit compare against NUM_SONGS-1 and 0. It never relies on SONG_W overflow, so e.g. NUM_SONGS=3 is valid.

## Timing
- All outputs are registered. An input sampled at edge N is reflected in the outputs after edge N, visible for cycle N+1. Latency is 1 cycle.
- `reset_player` is high for exactly one cycle per triggering event. It coincides with the cycle in which the new `song` value first appears.
- Back-to-back events on consecutive cycles are each honoured; there is no lockout.
- Behaviour after `reset` deasserts:
  - First edge with `reset`=0: `reset_player` returns to 0, unless an event fires on that edge.
  - Buttons on that edge are honoured normally.
- Reset mid-play or mid-strobe overrides everything at that edge.
- Inputs are assumed already synchronised and one-pulsed upstream. A held level is treated as one event per cycle.

## Test plan
- Default params, from reset: pulse `play_button` → `play`=1 next cycle, `reset_player`=0. Pulse again → `play`=0, `song` stays 0.
- NUM_SONGS=3, PAUSED:
  - Pulse `next` 3 times → `song` goes 1, 2, 0, each with a 1-cycle `reset_player`, `play` stays 0.
  - Then pulse `prev` → `song`=2.
  - Then `next` and `prev` in the same cycle → `song` stays 2, no strobe.
- ADVANCE (one `mode_button`) while PLAYING on song 2 of 4:
  - `song_done` → `song`=3, `play`=1, strobe.
  - `song_done` again → `song`=0, `play`=0, strobe.
- Mode coverage while PLAYING song 1 of 4:
  - STOP: `song_done` → `play`=0, `song`=1.
  - LOOP_ALL on song 3: `song_done` → `song`=0, `play`=1.
  - REPEAT_ONE: `song_done` → `song` unchanged, `play`=1, strobe.
  - `song_done` while PAUSED in any mode → no change.
- Simultaneous `song_done` + `play_button` while PLAYING in LOOP_ALL → song advances, `play` stays 1 (the play toggle is dropped). `mode_button` held 5 cycles → `mode` goes 1, 2, 3, 0, 1.
- Reset while PLAYING song 3, mode 2 → after the edge `play`=0, `song`=0, `mode`=0, `reset_player`=1. On the next edge (with `reset` low) `reset_player`=0. A `play_button` pulse then gives `play`=1.

Source files
------------

// File: rtl/playlist_mcu.sv
// playlist_mcu: playback controller between the button one-pulsers and the
// song reader / note player. Produces the play enable, the selected song
// index, the end-of-song mode and a one-cycle player restart strobe.
module playlist_mcu #(
   parameter int NUM_SONGS = 4,
   parameter int SONG_W    = 2
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              play_button,
   input  logic              next_button,
   input  logic              prev_button,
   input  logic              mode_button,
   input  logic              song_done,
   output logic              play,
   output logic              reset_player,
   output logic [SONG_W-1:0] song,
   output logic [1:0]        mode
);

   typedef enum logic {
      PAUSED  = 1'b0,
      PLAYING = 1'b1
   } state_t;

   localparam logic [1:0] MODE_STOP       = 2'd0;
   localparam logic [1:0] MODE_ADVANCE    = 2'd1;
   localparam logic [1:0] MODE_LOOP_ALL   = 2'd2;
   localparam logic [1:0] MODE_REPEAT_ONE = 2'd3;

   localparam logic [SONG_W-1:0] LAST_SONG = SONG_W'(NUM_SONGS - 1);

   state_t            r_state;
   logic [SONG_W-1:0] r_song;
   logic [1:0]        r_mode;
   logic              r_strobe;

   state_t            w_nextState;
   logic [SONG_W-1:0] w_nextSong;
   logic              w_nextStrobe;
   logic [SONG_W-1:0] w_songInc;
   logic [SONG_W-1:0] w_songDec;
   logic              w_doneActs;
   logic              w_stepActs;

   // Neighbouring song indices, wrapped by explicit compare so that song
   // counts that are not a power of two never reach an illegal index.
   always_comb begin
      w_songInc = (r_song == LAST_SONG) ? '0 : r_song + SONG_W'(1);
      w_songDec = (r_song == '0) ? LAST_SONG : r_song - SONG_W'(1);
   end

   // Next state, song and strobe: song_done beats a single next/prev,
   // which beats the play toggle; next and prev together cancel out.
   always_comb begin
      w_nextState  = r_state;
      w_nextSong   = r_song;
      w_nextStrobe = 1'b0;
      w_doneActs   = song_done && (r_state == PLAYING);
      w_stepActs   = next_button ^ prev_button;
      if (w_doneActs) begin
         w_nextStrobe = 1'b1;
         case (r_mode)
            MODE_STOP: begin
               w_nextState = PAUSED;
            end
            MODE_ADVANCE: begin
               if (r_song == LAST_SONG) begin
                  w_nextSong  = '0;
                  w_nextState = PAUSED;
               end else begin
                  w_nextSong = w_songInc;
               end
            end
            MODE_LOOP_ALL: begin
               w_nextSong = w_songInc;
            end
            MODE_REPEAT_ONE: begin
               w_nextSong = r_song;
            end
            default: begin
               w_nextState = PAUSED;
            end
         endcase
      end else if (w_stepActs) begin
         w_nextStrobe = 1'b1;
         w_nextSong   = next_button ? w_songInc : w_songDec;
      end else if (play_button) begin
         w_nextState = (r_state == PLAYING) ? PAUSED : PLAYING;
      end
   end

   // State, song and strobe registers; reset holds the player cleared.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_state  <= PAUSED;
         r_song   <= '0;
         r_strobe <= 1'b1;
      end else begin
         r_state  <= w_nextState;
         r_song   <= w_nextSong;
         r_strobe <= w_nextStrobe;
      end
   end

   // Mode register cycles independently of the playback events; a new mode
   // only governs song_done on later edges because the case above reads r_mode.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_mode <= MODE_STOP;
      end else if (mode_button) begin
         r_mode <= r_mode + 2'd1;
      end
   end

   assign play         = (r_state == PLAYING);
   assign reset_player = r_strobe;
   assign song         = r_song;
   assign mode         = r_mode;

endmodule

// File: tb/tb_playlist_mcu.sv
// tb_playlist_mcu: directed scenarios plus randomized traffic for
// playlist_mcu, run on a 4-song and a 3-song instance in parallel.
module tb_playlist_mcu;

   logic clk;
   logic rst, pb, nb, pvb, mb, sd;

   logic       play4, rp4;
   logic [1:0] song4, mode4;
   logic       play3, rp3;
   logic [1:0] song3, mode3;

   int vectors;
   int miscompares;

   // Reference model state, index 0 = 4-song instance, 1 = 3-song instance
   int mN[2];
   int mSong[2];
   int mMode[2];
   bit mPlay[2];
   bit mStrobe[2];

   playlist_mcu #(.NUM_SONGS(4), .SONG_W(2)) dut4 (
      .clk(clk), .reset(rst), .play_button(pb), .next_button(nb),
      .prev_button(pvb), .mode_button(mb), .song_done(sd),
      .play(play4), .reset_player(rp4), .song(song4), .mode(mode4)
   );

   playlist_mcu #(.NUM_SONGS(3), .SONG_W(2)) dut3 (
      .clk(clk), .reset(rst), .play_button(pb), .next_button(nb),
      .prev_button(pvb), .mode_button(mb), .song_done(sd),
      .play(play3), .reset_player(rp3), .song(song3), .mode(mode3)
   );

   // Free-running clock
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Behavioural model of one edge, written directly from the playback rules
   task automatic modelEdge(input int k);
      int newMode;
      if (rst) begin
         mPlay[k] = 0; mSong[k] = 0; mMode[k] = 0; mStrobe[k] = 1;
         return;
      end
      newMode = mb ? (mMode[k] + 1) % 4 : mMode[k];
      mStrobe[k] = 0;
      if (sd && mPlay[k]) begin
         mStrobe[k] = 1;
         if (mMode[k] == 0) mPlay[k] = 0;
         else if (mMode[k] == 1) begin
            if (mSong[k] < mN[k] - 1) mSong[k] = mSong[k] + 1;
            else begin mSong[k] = 0; mPlay[k] = 0; end
         end
         else if (mMode[k] == 2) mSong[k] = (mSong[k] + 1) % mN[k];
      end else if (nb && !pvb) begin
         mSong[k] = (mSong[k] + 1) % mN[k]; mStrobe[k] = 1;
      end else if (pvb && !nb) begin
         mSong[k] = (mSong[k] + mN[k] - 1) % mN[k]; mStrobe[k] = 1;
      end else if (pb) begin
         mPlay[k] = !mPlay[k];
      end
      mMode[k] = newMode;
   endtask

   // Apply one cycle of inputs, let the edge pass, advance the model
   task automatic applyStimulus(input bit r, input bit p, input bit n,
                                input bit v, input bit m, input bit d);
      rst = r; pb = p; nb = n; pvb = v; mb = m; sd = d;
      @(posedge clk);
      #1;
      modelEdge(0);
      modelEdge(1);
   endtask

   task automatic test_reset();
      applyStimulus(1, 1, 1, 0, 1, 1);
      applyStimulus(1, 0, 0, 0, 0, 0);
      vectors++; if (play4 !== 1'b0) begin miscompares++; $display("FAIL reset_play got %0b want 0", play4); end
      vectors++; if (song4 !== 2'd0) begin miscompares++; $display("FAIL reset_song got %0d want 0", song4); end
      vectors++; if (mode4 !== 2'd0) begin miscompares++; $display("FAIL reset_mode got %0d want 0", mode4); end
      vectors++; if (rp4 !== 1'b1) begin miscompares++; $display("FAIL reset_strobe got %0b want 1", rp4); end
      applyStimulus(0, 0, 0, 0, 0, 0);
      vectors++; if (rp4 !== 1'b0) begin miscompares++; $display("FAIL post_reset_strobe got %0b want 0", rp4); end
   endtask

   task automatic test_play_toggle();
      applyStimulus(0, 1, 0, 0, 0, 0);
      vectors++; if (play4 !== 1'b1 || rp4 !== 1'b0) begin miscompares++; $display("FAIL play_on got play=%0b rp=%0b want 1 0", play4, rp4); end
      applyStimulus(0, 1, 0, 0, 0, 0);
      vectors++; if (play4 !== 1'b0 || song4 !== 2'd0) begin miscompares++; $display("FAIL play_off got play=%0b song=%0d want 0 0", play4, song4); end
   endtask

   task automatic test_next_prev();
      int expSeq[3] = '{1, 2, 0};
      applyStimulus(1, 0, 0, 0, 0, 0);
      for (int i = 0; i < 3; i++) begin
         applyStimulus(0, 0, 1, 0, 0, 0);
         vectors++; if (song3 !== 2'(expSeq[i]) || rp3 !== 1'b1 || play3 !== 1'b0) begin miscompares++; $display("FAIL next3_%0d got song=%0d rp=%0b play=%0b want %0d 1 0", i, song3, rp3, play3, expSeq[i]); end
         applyStimulus(0, 0, 0, 0, 0, 0);
         vectors++; if (rp3 !== 1'b0) begin miscompares++; $display("FAIL next3_strobe_end_%0d got %0b want 0", i, rp3); end
      end
      applyStimulus(0, 0, 0, 1, 0, 0);
      vectors++; if (song3 !== 2'd2 || rp3 !== 1'b1) begin miscompares++; $display("FAIL prev3_wrap got song=%0d rp=%0b want 2 1", song3, rp3); end
      applyStimulus(0, 0, 1, 1, 0, 0);
      vectors++; if (song3 !== 2'd2 || rp3 !== 1'b0) begin miscompares++; $display("FAIL next_prev_cancel got song=%0d rp=%0b want 2 0", song3, rp3); end
   endtask

   task automatic test_advance();
      applyStimulus(1, 0, 0, 0, 0, 0);
      applyStimulus(0, 1, 0, 0, 1, 0);
      applyStimulus(0, 0, 1, 0, 0, 0);
      applyStimulus(0, 0, 1, 0, 0, 0);
      vectors++; if (song4 !== 2'd2 || play4 !== 1'b1 || mode4 !== 2'd1) begin miscompares++; $display("FAIL adv_setup got song=%0d play=%0b mode=%0d want 2 1 1", song4, play4, mode4); end
      applyStimulus(0, 0, 0, 0, 0, 1);
      vectors++; if (song4 !== 2'd3 || play4 !== 1'b1 || rp4 !== 1'b1) begin miscompares++; $display("FAIL adv_step got song=%0d play=%0b rp=%0b want 3 1 1", song4, play4, rp4); end
      applyStimulus(0, 0, 0, 0, 0, 1);
      vectors++; if (song4 !== 2'd0 || play4 !== 1'b0 || rp4 !== 1'b1) begin miscompares++; $display("FAIL adv_end got song=%0d play=%0b rp=%0b want 0 0 1", song4, play4, rp4); end
   endtask

   task automatic test_modes();
      applyStimulus(1, 0, 0, 0, 0, 0);
      applyStimulus(0, 1, 0, 0, 0, 0);
      applyStimulus(0, 0, 1, 0, 0, 0);
      applyStimulus(0, 0, 0, 0, 0, 1);
      vectors++; if (play4 !== 1'b0 || song4 !== 2'd1 || rp4 !== 1'b1) begin miscompares++; $display("FAIL stop_mode got play=%0b song=%0d rp=%0b want 0 1 1", play4, song4, rp4); end
      applyStimulus(0, 0, 0, 0, 1, 0);
      applyStimulus(0, 1, 0, 0, 1, 0);
      applyStimulus(0, 0, 1, 0, 0, 0);
      applyStimulus(0, 0, 1, 0, 0, 0);
      applyStimulus(0, 0, 0, 0, 0, 1);
      vectors++; if (song4 !== 2'd0 || play4 !== 1'b1 || mode4 !== 2'd2) begin miscompares++; $display("FAIL loop_all got song=%0d play=%0b mode=%0d want 0 1 2", song4, play4, mode4); end
      applyStimulus(0, 0, 0, 0, 1, 0);
      applyStimulus(0, 0, 0, 0, 0, 1);
      vectors++; if (song4 !== 2'd0 || play4 !== 1'b1 || rp4 !== 1'b1) begin miscompares++; $display("FAIL repeat_one got song=%0d play=%0b rp=%0b want 0 1 1", song4, play4, rp4); end
      applyStimulus(0, 1, 0, 0, 0, 0);
      applyStimulus(0, 0, 0, 0, 0, 1);
      vectors++; if (song4 !== 2'd0 || play4 !== 1'b0 || rp4 !== 1'b0) begin miscompares++; $display("FAIL done_paused got song=%0d play=%0b rp=%0b want 0 0 0", song4, play4, rp4); end
   endtask

   task automatic test_back_to_back();
      int expMode[5] = '{1, 2, 3, 0, 1};
      applyStimulus(1, 0, 0, 0, 0, 0);
      applyStimulus(0, 0, 0, 0, 1, 0);
      applyStimulus(0, 1, 0, 0, 1, 0);
      applyStimulus(0, 1, 0, 0, 0, 1);
      vectors++; if (song4 !== 2'd1 || play4 !== 1'b1 || rp4 !== 1'b1) begin miscompares++; $display("FAIL done_beats_play got song=%0d play=%0b rp=%0b want 1 1 1", song4, play4, rp4); end
      applyStimulus(1, 0, 0, 0, 0, 0);
      for (int i = 0; i < 5; i++) begin
         applyStimulus(0, 0, 0, 0, 1, 0);
         vectors++; if (mode4 !== 2'(expMode[i])) begin miscompares++; $display("FAIL mode_hold_%0d got %0d want %0d", i, mode4, expMode[i]); end
      end
   endtask

   task automatic test_reset_mid();
      applyStimulus(1, 0, 0, 0, 0, 0);
      applyStimulus(0, 1, 0, 1, 1, 0);
      applyStimulus(0, 1, 0, 0, 1, 0);
      vectors++; if (song4 !== 2'd3 || play4 !== 1'b1 || mode4 !== 2'd2) begin miscompares++; $display("FAIL mid_setup got song=%0d play=%0b mode=%0d want 3 1 2", song4, play4, mode4); end
      applyStimulus(1, 1, 1, 0, 1, 1);
      vectors++; if (play4 !== 1'b0 || song4 !== 2'd0 || mode4 !== 2'd0 || rp4 !== 1'b1) begin miscompares++; $display("FAIL mid_reset got play=%0b song=%0d mode=%0d rp=%0b want 0 0 0 1", play4, song4, mode4, rp4); end
      applyStimulus(0, 0, 0, 0, 0, 0);
      vectors++; if (rp4 !== 1'b0) begin miscompares++; $display("FAIL mid_release got rp=%0b want 0", rp4); end
      applyStimulus(0, 1, 0, 0, 0, 0);
      vectors++; if (play4 !== 1'b1) begin miscompares++; $display("FAIL mid_resume got play=%0b want 1", play4); end
   endtask

   task automatic test_random();
      int gotSong, gotMode;
      bit gotPlay, gotRp;
      applyStimulus(1, 0, 0, 0, 0, 0);
      for (int c = 0; c < 400; c++) begin
         applyStimulus($urandom_range(0, 49) == 0, $urandom_range(0, 3) == 0,
                       $urandom_range(0, 4) == 0, $urandom_range(0, 4) == 0,
                       $urandom_range(0, 5) == 0, $urandom_range(0, 2) == 0);
         for (int k = 0; k < 2; k++) begin
            gotSong = (k == 0) ? int'(song4) : int'(song3);
            gotMode = (k == 0) ? int'(mode4) : int'(mode3);
            gotPlay = (k == 0) ? play4 : play3;
            gotRp   = (k == 0) ? rp4 : rp3;
            vectors++;
            if (gotSong !== mSong[k] || gotMode !== mMode[k] || gotPlay !== mPlay[k] || gotRp !== mStrobe[k]) begin
               miscompares++;
               $display("FAIL rand_n%0d_c%0d got song=%0d mode=%0d play=%0b rp=%0b want %0d %0d %0b %0b",
                        mN[k], c, gotSong, gotMode, gotPlay, gotRp, mSong[k], mMode[k], mPlay[k], mStrobe[k]);
            end
         end
      end
   endtask

   // Scenario sequence and summary
   initial begin
      vectors = 0; miscompares = 0;
      mN[0] = 4; mN[1] = 3;
      for (int k = 0; k < 2; k++) begin
         mSong[k] = 0; mMode[k] = 0; mPlay[k] = 0; mStrobe[k] = 1;
      end
      rst = 1'b1; pb = 1'b0; nb = 1'b0; pvb = 1'b0; mb = 1'b0; sd = 1'b0;
      test_reset();
      test_play_toggle();
      test_next_prev();
      test_advance();
      test_modes();
      test_back_to_back();
      test_reset_mid();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
